// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: compares EX outcome with the fetch-time prediction,
// issues redirect/flush on mispredict, queues BTB updates and keeps saturating stats.
module branch_resolve_ctrl #(
  parameter int unsigned PCW          = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned UQ_DEPTH     = 4,
  parameter int unsigned CNTW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_valid,
  input  logic            EX_brn,
  input  logic [PCW-1:0]  EX_pc,
  input  logic [PCW-1:0]  EX_alu_out,
  input  logic            EX_true_taken,
  input  logic            EX_pred_taken,
  input  logic [PCW-1:0]  EX_pred_target,
  output logic            redirect_valid,
  output logic [PCW-1:0]  redirect_pc,
  output logic            flush,
  output logic            upd_valid,
  output logic [PCW-1:0]  upd_pc,
  output logic [PCW-1:0]  upd_target,
  output logic            upd_taken,
  input  logic            upd_ready,
  output logic            upd_drop,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] br_cnt,
  output logic [CNTW-1:0] mis_cnt
);

  localparam int unsigned AW = $clog2(UQ_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_fcnt, w_fcnt_nxt;

  logic            w_run;
  logic            w_resolve;
  logic            w_mispredict;
  logic [PCW-1:0]  w_correct_pc;

  logic            r_redirect_valid;
  logic [PCW-1:0]  r_redirect_pc;
  logic            r_drop;

  logic [PCW-1:0]  r_q_pc  [UQ_DEPTH];
  logic [PCW-1:0]  r_q_tgt [UQ_DEPTH];
  logic            r_q_tkn [UQ_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            w_full, w_empty, w_push, w_pop, w_write;

  logic [CNTW-1:0] r_br_cnt, r_mis_cnt;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      RUN: begin
        if (w_mispredict) begin
          w_state_nxt = FLUSH;
          w_fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (r_fcnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_fcnt_nxt = r_fcnt - 3'd1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_run = (r_state == RUN);
    flush = (r_state == FLUSH);
  end

  assign w_resolve    = w_run & EX_valid & EX_brn;
  assign w_mispredict = w_resolve &
                        ((EX_true_taken != EX_pred_taken) |
                         (EX_true_taken & EX_pred_taken & (EX_alu_out != EX_pred_target)));
  assign w_correct_pc = EX_true_taken ? EX_alu_out : (EX_pc + PCW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_correct_pc;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(UQ_DEPTH));
  assign w_push  = w_resolve;
  assign w_pop   = ~w_empty & upd_ready;
  // A push into a full queue still lands when the head is popped in the same cycle.
  assign w_write = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_q_pc[r_wptr]  <= EX_pc;
      r_q_tgt[r_wptr] <= EX_alu_out;
      r_q_tkn[r_wptr] <= EX_true_taken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_push & w_full & ~w_pop;
      if (w_write) r_wptr <= r_wptr + AW'(1);
      if (w_pop)   r_rptr <= r_rptr + AW'(1);
      if (w_write & ~w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (~w_write & w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Head fields are zeroed while empty so stale storage never leaks out.
  assign upd_valid  = ~w_empty;
  assign upd_pc     = w_empty ? '0   : r_q_pc[r_rptr];
  assign upd_target = w_empty ? '0   : r_q_tgt[r_rptr];
  assign upd_taken  = w_empty ? 1'b0 : r_q_tkn[r_rptr];
  assign upd_drop   = r_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (cnt_clr) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_resolve && r_br_cnt != '1)     r_br_cnt  <= r_br_cnt + CNTW'(1);
      if (w_mispredict && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNTW'(1);
    end
  end

  assign br_cnt  = r_br_cnt;
  assign mis_cnt = r_mis_cnt;

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences branch resolution between the EX stage, the front end and the 8-entry branch target buffer.
Each cycle it compares the resolved branch outcome in EX against the prediction carried down the pipe. On a mispredict it issues a registered redirect and a multi-cycle front-end flush.
Every resolved branch is queued as a BTB update and drained through a ready/valid port. Saturating branch and mispredict statistics are kept.

Parameters:
PCW, 5, PC width in bits (PC increments by 1 per instruction)
FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict (1..7)
UQ_DEPTH, 4, BTB update queue entries (power of 2, >=2)
CNTW, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
EX_valid  in  1  EX holds a real instruction
EX_brn  in  1  EX instruction is a branch
EX_pc  in  PCW  PC of the EX branch
EX_alu_out  in  PCW  resolved target PC
EX_true_taken  in  1  resolved direction
EX_pred_taken  in  1  direction predicted at fetch
EX_pred_target  in  PCW  target predicted at fetch
redirect_valid  out  1  one-cycle pulse: load redirect_pc into the fetch PC
redirect_pc  out  PCW  corrected next PC
flush  out  1  kill IF/ID contents
upd_valid  out  1  queue head valid
upd_pc  out  PCW  head PC
upd_target  out  PCW  head target
upd_taken  out  1  head direction
upd_ready  in  1  BTB accepts the update this cycle
upd_drop  out  1  one-cycle pulse: resolved branch lost because the queue was full
cnt_clr  in  1  synchronous clear of the counters
br_cnt  out  CNTW  resolved branches, saturating
mis_cnt  out  CNTW  mispredicts, saturating

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - redirect_valid=0, redirect_pc=0, flush=0, upd_drop=0
  - queue empty, so upd_valid=0 and upd_pc/upd_target/upd_taken=0
  - counters 0, FSM in RUN
- A resolve event is EX_valid & EX_brn while the FSM is in RUN. Branches in EX during FLUSH are wrong-path and are ignored entirely: no push, no count, no redirect.
- Mispredict = resolve & ((EX_true_taken != EX_pred_taken) | (EX_true_taken & EX_pred_taken & (EX_alu_out != EX_pred_target))).
- Corrected PC = EX_true_taken ? EX_alu_out : EX_pc+1, modulo 2^PCW. EX_pc=31 gives 0.
- FSM states:
  - RUN: on mispredict, the next cycle has redirect_valid=1, redirect_pc=corrected PC, flush=1, flush counter loaded with FLUSH_CYCLES-1, and the state becomes FLUSH.
  - FLUSH: flush=1 and redirect_valid=0. The counter decrements each cycle; the state returns to RUN in the cycle after the counter reads 0.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles, starting in the redirect cycle.
- redirect_pc holds its last value when redirect_valid=0.
- Latency: resolve in cycle N, so redirect, flush and queue push all take effect at the edge ending cycle N (visible in N+1).
- Update queue:
  - FIFO; each resolve pushes {EX_pc, EX_alu_out, EX_true_taken}.
  - Pop on upd_valid & upd_ready. upd_* shows the head combinationally from storage.
  - Push and pop in the same cycle are both honoured, including when full (count unchanged) and when empty (the entry is written; upd_valid rises the next cycle).
  - Push while full with no pop: the entry is dropped, upd_drop pulses the next cycle, and the queue is unchanged.
  - Pointers wrap modulo UQ_DEPTH. An occupancy counter of log2(UQ_DEPTH)+1 bits distinguishes full from empty.
  - The queue is not cleared by a mispredict, because resolved branches are architecturally correct.
- Counters:
  - br_cnt +1 per resolve; mis_cnt +1 per mispredict; both stick at 2^CNTW-1.
  - cnt_clr has priority over increment, so a clear coincident with an event yields 0.
- EX_valid=0 or EX_brn=0: no action regardless of the other inputs.
- Reset asserted mid-FLUSH or with a non-empty queue: everything returns to reset values immediately. No redirect or update is produced after release until a new resolve.

Test Plan:
- Correct prediction: resolve with EX_pc=4, pred_taken=1, pred_target=12, true_taken=1, alu_out=12 -> no redirect, flush=0, next cycle upd_valid=1 with {4,12,1}, br_cnt=1, mis_cnt=0.
- Direction mispredict: resolve with EX_pc=31, pred_taken=1, true_taken=0 -> next cycle redirect_valid=1, redirect_pc=0, flush high for exactly 2 cycles, mis_cnt=1. A branch in EX during both flush cycles causes no push and no count.
- Target mispredict: pred_taken=1, true_taken=1, pred_target=9, alu_out=20 -> redirect_pc=20, flush for 2 cycles.
- Queue full: upd_ready=0, 5 resolves at PCs 1..5 -> entries 1..4 retained, upd_drop pulses once (for PC 5). Then upd_ready=1 drains 1,2,3,4 in order and upd_valid falls.
- Push and pop while full: queue full, upd_ready=1, new resolve at PC 7 -> no drop, occupancy stays 4, PC 7 appears last.
- Reset and counters: rst=0 asserted mid-flush -> flush=0 asynchronously and queue empty. Drive br_cnt to 0xFFFF -> it saturates. cnt_clr with a coincident resolve -> 0.
